// File: rtl/wb_regfile_slave_pkg.sv
// Shared definitions for the Wishbone register-file slave.
//   state_t          : bus handshake FSM states (IDLE / WAIT / RESP)
//   REG_WR_CNT/REG_ID: indices of the two read-only registers
//   *_DEFAULT/RESET  : parameter defaults and register reset value
package wb_regfile_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int          NUM_REGS    = 16;
  localparam int          NUM_RW_REGS = 14;

  localparam logic [3:0]  REG_WR_CNT  = 4'd14;
  localparam logic [3:0]  REG_ID      = 4'd15;

  localparam logic [31:0] RESET_VALUE      = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_BASE_ADR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hC0DE_0001;

endpackage

// File: rtl/wb_regfile_bank.sv
// Register storage for the Wishbone register-file slave.
//   Registers 0..13 : read/write, byte-lane masked by wr_sel
//   Register 14     : write counter, +1 on every committed write (any index)
//   Register 15     : constant ID_VALUE
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   wr_en        : commit one write this edge
//   wr_idx/wr_data/wr_sel : write target, data, byte-lane enables
//   rd_idx/rd_data        : combinational read port
module wb_regfile_bank
  import wb_regfile_slave_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = DEFAULT_ID_VALUE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_sel,
  input  logic [3:0]  rd_idx,
  output logic [31:0] rd_data
);

  logic [31:0] rw_regs [NUM_RW_REGS];
  logic [31:0] wr_cnt;

  // NOTE: the array is reset explicitly because every register must read
  // zero after reset; with only 14 words this stays flop-based, not RAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_RW_REGS; i++) rw_regs[i] <= RESET_VALUE;
      wr_cnt <= RESET_VALUE;
    end else if (wr_en) begin
      // Writes to the read-only slots are still counted.
      wr_cnt <= wr_cnt + 32'd1;
      if (wr_idx < REG_WR_CNT) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_sel[b]) rw_regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // NOTE: rd_data gets a default before the branches so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = '0;
    if (rd_idx == REG_ID)          rd_data = ID_VALUE;
    else if (rd_idx == REG_WR_CNT) rd_data = wr_cnt;
    else                           rd_data = rw_regs[rd_idx];
  end

endmodule

// File: rtl/wb_regfile_slave.sv
// Wishbone classic slave exposing 16 x 32-bit registers at BASE_ADR.
// Each access is latched in IDLE, optionally delayed WAIT_STATES cycles,
// then terminated with a one-cycle registered ack_o (hit) or err_o (miss).
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   adr_i, dat_i, we_i,
//   sel_i, stb_i, cyc_i   : Wishbone master request
//   dat_o, ack_o, err_o   : Wishbone response
module wb_regfile_slave
  import wb_regfile_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = DEFAULT_BASE_ADR,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;

  // Request captured at the accepting edge.
  logic [3:0]  lat_idx;
  logic [31:0] lat_dat;
  logic        lat_we;
  logic [3:0]  lat_sel;
  logic        lat_hit;

  logic        req, accept, addr_hit;
  logic        commit_wr, ack_nxt, err_nxt;
  logic [31:0] dat_nxt, rd_data;

  assign req      = cyc_i & stb_i;
  // ack_o/err_o are high while the FSM is already back in IDLE; blocking
  // acceptance then guarantees an idle cycle between accesses.
  assign accept   = (state == ST_IDLE) & req & ~ack_o & ~err_o;
  assign addr_hit = (adr_i[31:6] == BASE_ADR[31:6]) & (adr_i[1:0] == 2'b00);

  // State register, captured request and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      lat_idx <= '0;
      lat_dat <= '0;
      lat_we  <= 1'b0;
      lat_sel <= '0;
      lat_hit <= 1'b0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      dat_o   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_idx <= adr_i[5:2];
        lat_dat <= dat_i;
        lat_we  <= we_i;
        lat_sel <= sel_i;
        lat_hit <= addr_hit;
      end
      ack_o <= ack_nxt;
      err_o <= err_nxt;
      dat_o <= dat_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_nxt   = WS;
          state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - 3'd1;
        // Abort wins over completion on the final wait edge.
        if (!req)           state_nxt = ST_IDLE;
        else if (cnt == 3'd1) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: RESP drives the edge that raises ack/err and commits.
  always_comb begin
    commit_wr = 1'b0;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    dat_nxt   = '0;
    if (state == ST_RESP) begin
      ack_nxt   = lat_hit;
      err_nxt   = ~lat_hit;
      commit_wr = lat_hit & lat_we;
      if (lat_hit && !lat_we) dat_nxt = rd_data;
    end
  end

  wb_regfile_bank #(
    .ID_VALUE(ID_VALUE)
  ) u_bank (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_en  (commit_wr),
    .wr_idx (lat_idx),
    .wr_data(lat_dat),
    .wr_sel (lat_sel),
    .rd_idx (lat_idx),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_wb_regfile_slave.sv
// Self-checking bench for wb_regfile_slave. Three instances cover
// WAIT_STATES = 1 (default), 3 and 0; each has its own handshake and reset
// lines and its own reference model of the register file.
module tb_wb_regfile_slave;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] ID   = 32'hC0DE_0001;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [2:0]  cyc = '0;
  logic [2:0]  stb = '0;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;

  wire  [2:0]        ack;
  wire  [2:0]        err;
  wire  [2:0][31:0]  dato;

  int checks = 0;
  int errors = 0;

  int          ws_of [3] = '{1, 3, 0};
  logic [31:0] mdl [3][16];

  always #5 clk = ~clk;

  wb_regfile_slave #(.BASE_ADR(BASE), .WAIT_STATES(1), .ID_VALUE(ID)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .adr_i(adr), .dat_i(dat_w), .we_i(we),
    .sel_i(sel), .stb_i(stb[0]), .cyc_i(cyc[0]),
    .dat_o(dato[0]), .ack_o(ack[0]), .err_o(err[0]));

  wb_regfile_slave #(.BASE_ADR(BASE), .WAIT_STATES(3), .ID_VALUE(ID)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .adr_i(adr), .dat_i(dat_w), .we_i(we),
    .sel_i(sel), .stb_i(stb[1]), .cyc_i(cyc[1]),
    .dat_o(dato[1]), .ack_o(ack[1]), .err_o(err[1]));

  wb_regfile_slave #(.BASE_ADR(BASE), .WAIT_STATES(0), .ID_VALUE(ID)) dut2 (
    .clk_i(clk), .rst_i(rst[2]), .adr_i(adr), .dat_i(dat_w), .we_i(we),
    .sel_i(sel), .stb_i(stb[2]), .cyc_i(cyc[2]),
    .dat_o(dato[2]), .ack_o(ack[2]), .err_o(err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    for (int k = 0; k < 16; k++) mdl[d][k] = (k == 15) ? ID : 32'h0;
  endtask

  // Behavioural model: address arithmetic on the byte offset from BASE.
  task automatic model_access(input int d, input logic [31:0] a, input logic [31:0] wd,
                              input logic w, input logic [3:0] s,
                              output logic e_ack, output logic e_err, output logic [31:0] e_dat);
    longint off;
    int     k;
    off   = longint'(a) - longint'(BASE);
    e_dat = 32'h0;
    if (off < 0 || off >= 64 || (off % 4) != 0) begin
      e_ack = 1'b0;
      e_err = 1'b1;
      return;
    end
    e_ack = 1'b1;
    e_err = 1'b0;
    k = int'(off / 4);
    if (w) begin
      mdl[d][14] = mdl[d][14] + 32'd1;
      if (k < 14) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mdl[d][k][8*b +: 8] = wd[8*b +: 8];
      end
    end else begin
      e_dat = mdl[d][k];
    end
  endtask

  // One complete access on instance d, checked against the model.
  task automatic bus(input int d, input logic [31:0] a, input logic [31:0] wd,
                     input logic w, input logic [3:0] s, input string tag);
    int          lat;
    logic        seen;
    logic        e_ack, e_err;
    logic [31:0] e_dat;
    model_access(d, a, wd, w, s, e_ack, e_err, e_dat);
    @(negedge clk);
    adr = a; dat_w = wd; we = w; sel = s; cyc[d] = 1'b1; stb[d] = 1'b1;
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ack[d] || err[d]) seen = 1'b1;
    end
    check({tag, ":term"}, 32'(seen), 32'd1);
    check({tag, ":lat"},  32'(lat),  32'(ws_of[d] + 1));
    check({tag, ":ack"},  32'(ack[d]), 32'(e_ack));
    check({tag, ":err"},  32'(err[d]), 32'(e_err));
    check({tag, ":dat"},  dato[d], e_dat);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(negedge clk);
    check({tag, ":pulse"}, {30'h0, ack[d], err[d]}, 32'h0);
    check({tag, ":dat0"},  dato[d], 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [31:0] a;
    int          r;

    for (int d = 0; d < 3; d++) model_reset(d);
    rst = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst%0d:outs", d), {30'h0, ack[d], err[d]}, 32'h0);
      check($sformatf("rst%0d:dat", d), dato[d], 32'h0);
    end
    rst = 3'b000;

    // Basic reads after reset.
    bus(0, 32'h00, 32'h0, 1'b0, 4'h0, "rd00");
    bus(0, 32'h3C, 32'h0, 1'b0, 4'h0, "rdid");

    // Byte-lane write and write counter.
    bus(0, 32'h04, 32'hDEADBEEF, 1'b1, 4'b0101, "wr04");
    bus(0, 32'h04, 32'h0, 1'b0, 4'h0, "rd04");
    check("rd04:known", mdl[0][1], 32'h00AD00EF);
    bus(0, 32'h38, 32'h0, 1'b0, 4'h0, "rdcnt1");

    // Misses: out of range and misaligned, count untouched.
    bus(0, 32'h40, 32'h0, 1'b0, 4'h0, "miss40");
    bus(0, 32'h02, 32'h0, 1'b0, 4'h0, "miss02");
    bus(0, 32'h40, 32'h1234_5678, 1'b1, 4'hF, "misswr");
    bus(0, 32'h38, 32'h0, 1'b0, 4'h0, "rdcnt2");

    // Writes to read-only slots and sel = 0 are acked and counted.
    bus(0, 32'h38, 32'hFFFF_FFFF, 1'b1, 4'hF, "wrcnt");
    bus(0, 32'h3C, 32'hFFFF_FFFF, 1'b1, 4'hF, "wrid");
    bus(0, 32'h08, 32'hFFFF_FFFF, 1'b1, 4'h0, "wrsel0");
    bus(0, 32'h3C, 32'h0, 1'b0, 4'h0, "rdid2");
    bus(0, 32'h08, 32'h0, 1'b0, 4'h0, "rd08");
    bus(0, 32'h38, 32'h0, 1'b0, 4'h0, "rdcnt3");

    // Randomised traffic on the default instance.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else             a = BASE + 32'($urandom_range(0, 15) * 4);
      bus(0, a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          $sformatf("rnd%0d", i));
    end
    bus(0, 32'h38, 32'h0, 1'b0, 4'h0, "rdcnt4");

    // Abort in WAIT on the WAIT_STATES = 3 instance.
    bus(1, 32'h14, 32'h1234_5678, 1'b1, 4'hF, "ab:pre");
    bus(1, 32'h14, 32'h0, 1'b0, 4'h0, "ab:rdpre");
    @(negedge clk);
    adr = 32'h14; dat_w = 32'hFFFF_0000; we = 1'b1; sel = 4'hF;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stb[1] = 1'b0; cyc[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("ab:quiet%0d", i), {30'h0, ack[1], err[1]}, 32'h0);
    end
    bus(1, 32'h14, 32'h0, 1'b0, 4'h0, "ab:rdpost");
    bus(1, 32'h38, 32'h0, 1'b0, 4'h0, "ab:cnt");
    for (int i = 0; i < 10; i++)
      bus(1, BASE + 32'($urandom_range(0, 15) * 4), $urandom, 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), $sformatf("ws3rnd%0d", i));

    // Zero wait states: 20 back-to-back writes to the ID register.
    for (int i = 0; i < 20; i++)
      bus(2, 32'h3C, $urandom, 1'b1, 4'hF, $sformatf("ws0wr%0d", i));
    bus(2, 32'h3C, 32'h0, 1'b0, 4'h0, "ws0:id");
    bus(2, 32'h38, 32'h0, 1'b0, 4'h0, "ws0:cnt");
    check("ws0:cnt20", mdl[2][14], 32'd20);

    // Reset arriving while a write sits in RESP.
    bus(0, 32'h0C, 32'h5555_AAAA, 1'b1, 4'hF, "rr:pre");
    @(negedge clk);
    adr = 32'h0C; dat_w = 32'h1111_2222; we = 1'b1; sel = 4'hF;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk);               // accept -> WAIT
    @(posedge clk);               // WAIT -> RESP
    @(negedge clk);
    rst[0] = 1'b1;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rr:ack", {30'h0, ack[0], err[0]}, 32'h0);
    check("rr:dat", dato[0], 32'h0);
    rst[0] = 1'b0;
    model_reset(0);
    for (int k = 0; k < 16; k++)
      bus(0, BASE + 32'(k * 4), 32'h0, 1'b0, 4'h0, $sformatf("rr:rd%0d", k));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile_slave.md
WB_REGFILE_SLAVE -- requirements
Module: wb_regfile_slave

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i, rst_i.
REQ-002 Parameter BASE_ADR, default 32'h0000_0000, SHALL be the byte address of register 0.
REQ-003 Parameter WAIT_STATES, default 1, range 0..7, SHALL be the number of idle cycles inserted before ack_o.
REQ-004 Parameter ID_VALUE, default 32'hC0DE_0001, SHALL be the constant read from register 15.
REQ-005 Ports, as name direction width meaning:
  clk_i    in   1   clock
  rst_i    in   1   synchronous active-high reset
  adr_i    in   32  byte address from master
  dat_i    in   32  write data from master
  we_i     in   1   1 = write, 0 = read
  sel_i    in   4   byte lane enables, bit n = dat[8n+7:8n]
  stb_i    in   1   strobe
  cyc_i    in   1   bus cycle active
  dat_o    out  32  read data
  ack_o    out  1   normal termination
  err_o    out  1   error termination (address miss)

Function
REQ-006 The block SHALL hold 16 x 32-bit registers at BASE_ADR + 4*k, k = adr_i[5:2].
REQ-007 An access SHALL hit when adr_i[31:6] == BASE_ADR[31:6] and adr_i[1:0] == 0. Otherwise it SHALL miss.
REQ-008 Registers 0..13 SHALL be read/write. Register 14 (WR_CNT) and register 15 (ID) SHALL be read-only.
REQ-009 WR_CNT SHALL increment by 1, modulo 2^32, on every committed write. A committed write is a hit with we_i = 1, any sel_i, any k.
REQ-010 Writes to k = 14 or 15 SHALL be acked, SHALL not change the target register, and SHALL still increment WR_CNT.
REQ-011 A write SHALL update only the bytes enabled in sel_i. sel_i = 0 SHALL be acked and counted, with no data change.
REQ-012 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-013 IDLE: when cyc_i & stb_i is sampled high, the FSM SHALL go to WAIT with cnt = WAIT_STATES, or straight to RESP when WAIT_STATES = 0. Address, data, we and sel SHALL be latched at this edge.
REQ-014 WAIT: cnt SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where cnt is 1.
REQ-015 WAIT: if cyc_i or stb_i is sampled low, the FSM SHALL return to IDLE with no write, no ack and no err (abort).
REQ-016 RESP: exactly one of ack_o or err_o SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-017 Latency SHALL be WAIT_STATES + 1 cycles from the edge sampling stb to ack/err high.
REQ-018 The register write SHALL commit on the same edge that raises ack_o, using the latched values.
REQ-019 dat_o SHALL carry the latched-address register value while ack_o = 1 on a read. It SHALL be 0 at all other times, including on err and on write acks.
REQ-020 A read of WR_CNT in the same access as a write SHALL be impossible; a read SHALL return the count before any later write.
REQ-021 A new request SHALL NOT be accepted in the cycle ack_o or err_o is high. Back-to-back accesses SHALL have at least one IDLE cycle between them.

Reset
REQ-022 While rst_i = 1 at an edge: state SHALL be IDLE; registers 0..14 SHALL be 0; ack_o, err_o and dat_o SHALL be 0.
REQ-023 Reset SHALL take priority over every other event, including mid-WAIT or RESP. Any in-flight write SHALL be discarded.

Structure
REQ-024 A shared package SHALL hold the state enum, the register index constants (REG_WR_CNT = 14, REG_ID = 15) and the reset/ID default constants.
REQ-025 The register array with byte-lane write logic SHALL be one sub-module, wb_regfile_bank. The FSM and decode SHALL stay in the top level.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
  - Reset, then read 0x00 -> ack after 2 cycles, dat_o = 0; read 0x3C -> dat_o = 32'hC0DE_0001.
  - Write 0x04 = 32'hDEADBEEF with sel = 4'b0101, then read 0x04 -> 32'h00AD00EF; read 0x38 -> 1.
  - Read 0x40 and read 0x02 -> err_o pulse for one cycle, ack_o stays 0, dat_o = 0, WR_CNT unchanged.
  - Drop stb_i one cycle into WAIT (WAIT_STATES = 3) -> no ack/err; a following read of the target shows the old value.
  - Assert rst_i in RESP of a write -> no commit, all registers 0, ack_o = 0 the next cycle.
  - WAIT_STATES = 0, 20 back-to-back writes to 0x3C -> every one acked in 1 cycle, ID unchanged, WR_CNT = 20.
